voice_mixer: RTL

//  Downstream of the note players. Mixes NUM_VOICES per-voice samples into one codec sample.
//  On each codec sample request it collects one sample from every active voice.
//  It sums the samples, scales and saturates the sum, then presents the result to the codec

---
 rtl/voice_mixer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/voice_mixer.sv
// ----------------------------------------------------------------------------
// voice_mixer
//
// Mixes NUM_VOICES per-voice signed 16-bit samples into one codec sample.
// A codec request in IDLE starts a collection window.
// Each voice contributes the first sample it strobes during that window.
// The window closes as soon as every active voice has been captured, or after
// TIMEOUT cycles, whichever comes first.
// The captured samples are summed without wrap, shifted right arithmetically
// by SHIFT, saturated to 16 bits and presented with a one-cycle strobe.
//
// Ports
//   clk                   system clock
//   reset                 synchronous, active-high
//   generate_next_sample  codec request pulse
//   voice_active          [NUM_VOICES]    voices that must be waited on
//   voice_sample          [16*NUM_VOICES] signed samples, voice i at [16*i +: 16]
//   voice_ready           [NUM_VOICES]    per-voice sample strobe
//   sample_out            [16]  mixed sample, held until the next update
//   sample_ready          one-cycle strobe when sample_out updates
//   busy                  high whenever a mix is in progress
//   timeout_err           sticky: a collection window timed out
//   overrun_err           sticky: a request arrived while busy
// ----------------------------------------------------------------------------
module voice_mixer #(
    parameter int NUM_VOICES = 3,
    parameter int SHIFT      = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      generate_next_sample,
    input  logic [NUM_VOICES-1:0]     voice_active,
    input  logic [16*NUM_VOICES-1:0]  voice_sample,
    input  logic [NUM_VOICES-1:0]     voice_ready,
    output logic [15:0]               sample_out,
    output logic                      sample_ready,
    output logic                      busy,
    output logic                      timeout_err,
    output logic                      overrun_err
);

    // Accumulator is wide enough that the sum of all voices can never wrap.
    localparam int ACC_W = 16 + ((NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic signed [ACC_W-1:0] POS_LIM = {{(ACC_W-16){1'b0}}, 16'h7fff};
    localparam logic signed [ACC_W-1:0] NEG_LIM = {{(ACC_W-16){1'b1}}, 16'h8000};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SUM     = 2'd2,
        OUT     = 2'd3
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [NUM_VOICES-1:0]   flags;
    logic signed [15:0]      cap [NUM_VOICES];
    logic [CNT_W-1:0]        cnt;
    logic signed [ACC_W-1:0] sum;
    logic                    done;
    logic                    tmo_hit;

    // Shift then clamp the wide sum into the 16-bit signed range.
    function automatic logic [15:0] scale_sat(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] s;
        s = v >>> SHIFT;
        if (s > POS_LIM) begin
            scale_sat = 16'h7fff;
        end else if (s < NEG_LIM) begin
            scale_sat = 16'h8000;
        end else begin
            scale_sat = s[15:0];
        end
    endfunction

    // Sign-extended sum of every voice captured in this window.
    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (flags[i]) begin
                sum = sum + ACC_W'(cap[i]);
            end else begin
                sum = sum;
            end
        end
    end

    // Next-state logic; completion uses the registered capture flags so that a
    // capture on the current edge is only counted from the following cycle.
    always_comb begin
        next_state = state;
        done       = &(flags | ~voice_active);
        tmo_hit    = 1'b0;
        case (state)
            IDLE: begin
                if (generate_next_sample) begin
                    next_state = COLLECT;
                end else begin
                    next_state = IDLE;
                end
            end
            COLLECT: begin
                if (done) begin
                    next_state = SUM;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    next_state = SUM;
                    tmo_hit    = 1'b1;
                end else begin
                    next_state = COLLECT;
                end
            end
            SUM:     next_state = OUT;
            OUT:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register, capture registers, outputs and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            flags        <= '0;
            cnt          <= '0;
            sample_out   <= 16'h0000;
            sample_ready <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
            overrun_err  <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                cap[i] <= 16'sh0000;
            end
        end else begin
            state        <= next_state;
            busy         <= (next_state != IDLE);
            sample_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (generate_next_sample) begin
                        flags <= '0;
                        cnt   <= '0;
                    end
                end
                COLLECT: begin
                    cnt <= cnt + CNT_W'(1);
                    // First strobe per voice wins; later strobes are ignored.
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (voice_ready[i] && !flags[i]) begin
                            cap[i]   <= voice_sample[16*i +: 16];
                            flags[i] <= 1'b1;
                        end
                    end
                    if (tmo_hit) begin
                        timeout_err <= 1'b1;
                    end
                end
                SUM: begin
                    // Registered here so the new value and strobe appear in OUT.
                    sample_out   <= scale_sat(sum);
                    sample_ready <= 1'b1;
                end
                OUT: begin
                end
                default: begin
                end
            endcase
            // A request outside IDLE is dropped; the mix in progress continues.
            if (generate_next_sample && (state != IDLE)) begin
                overrun_err <= 1'b1;
            end
        end
    end

endmodule
